// File: rtl/apb_image_bank.sv
// apb_image_bank: APB-mapped parameter registers and image memory with a start/busy/done handshake to an image core
//   clk, rst          : clock, synchronous active-high reset
//   PSEL..PRDATA      : zero-wait-state APB slave (registered PRDATA)
//   Iwhite..Bmax,Np,Nw: parameter register outputs
//   start             : one-cycle run pulse to the core
//   Image_Done        : core completion, honoured only while busy
//   core_addr/core_data: core read port, one cycle latency
module apb_image_bank #(
  parameter int Amba_Word       = 16,
  parameter int Amba_Addr_Depth = 20,
  parameter int Data_Depth      = 8,
  parameter int Mem_Depth       = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         PSEL,
  input  logic                         PENABLE,
  input  logic                         PWRITE,
  input  logic [Amba_Addr_Depth:0]     PADDR,
  input  logic [Amba_Word-1:0]         PWDATA,
  output logic [Amba_Word-1:0]         PRDATA,
  output logic [Data_Depth-1:0]        Iwhite,
  output logic [Data_Depth-1:0]        M,
  output logic [Data_Depth-1:0]        Bthr,
  output logic [Data_Depth-1:0]        Amin,
  output logic [Data_Depth-1:0]        Amax,
  output logic [Data_Depth-1:0]        Bmin,
  output logic [Data_Depth-1:0]        Bmax,
  output logic [8:0]                   Np,
  output logic [8:0]                   Nw,
  output logic                         start,
  input  logic                         Image_Done,
  input  logic [$clog2(Mem_Depth)-1:0] core_addr,
  output logic [Data_Depth-1:0]        core_data
);
  localparam int AW = $clog2(Mem_Depth);
  localparam logic [Amba_Addr_Depth:0] MEM_LO = 10;
  localparam logic [Amba_Addr_Depth:0] MEM_N  = Mem_Depth;
  typedef enum logic [1:0] {IDLE, START, BUSY, DONE} state_t;
  state_t state;
  logic [Data_Depth-1:0] mem [Mem_Depth];
  logic busy, done, err;
  logic [Amba_Addr_Depth:0] off;
  logic [AW-1:0] idx;
  logic in_mem, we, cfg, ctl_wr, valid;
  logic [Data_Depth-1:0] wd;
  logic [31:0] need;
  logic [Amba_Word-1:0] rd;
  always_comb begin
    off    = PADDR - MEM_LO;
    in_mem = PADDR >= MEM_LO && off < MEM_N;
    idx    = off[AW-1:0];
    wd     = PWDATA[Data_Depth-1:0];
    we     = PSEL && PENABLE && PWRITE;
    cfg    = we && (state == IDLE || state == DONE);
    ctl_wr = we && PADDR == '0;
    need   = 32'(Np) * 32'(Np) + 32'(Nw) * 32'(Nw);
    valid  = Np != '0 && Nw != '0 && M != '0 && need <= 32'(Mem_Depth);
  end
  always_comb begin
    rd = '0;
    case (PADDR)
      0: rd = Amba_Word'({err, done, busy});
      1: rd = Amba_Word'(Iwhite);
      2: rd = Amba_Word'(Np);
      3: rd = Amba_Word'(Nw);
      4: rd = Amba_Word'(M);
      5: rd = Amba_Word'(Bthr);
      6: rd = Amba_Word'(Amin);
      7: rd = Amba_Word'(Amax);
      8: rd = Amba_Word'(Bmin);
      9: rd = Amba_Word'(Bmax);
      default: rd = in_mem && state != BUSY ? Amba_Word'(mem[idx]) : '0;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst && cfg && in_mem) mem[idx] <= wd;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      {Iwhite, M, Bthr, Amin, Amax, Bmin, Bmax} <= '0;
      Np        <= '0;
      Nw        <= '0;
      PRDATA    <= '0;
      core_data <= '0;
    end else begin
      core_data <= mem[core_addr];
      if (PSEL && !PWRITE) PRDATA <= rd;
      if (cfg)
        case (PADDR)
          1: Iwhite <= wd;
          2: Np     <= PWDATA[8:0];
          3: Nw     <= PWDATA[8:0];
          4: M      <= wd;
          5: Bthr   <= wd;
          6: Amin   <= wd;
          7: Amax   <= wd;
          8: Bmin   <= wd;
          9: Bmax   <= wd;
          default: ;
        endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      start <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else
      case (state)
        IDLE, DONE:
          if (ctl_wr && wd == Data_Depth'(1)) begin
            if (valid) begin
              state <= START;
              start <= 1'b1;
              done  <= 1'b0;
              err   <= 1'b0;
            end else err <= 1'b1;
          end else if (ctl_wr && wd == '0 && state == DONE) begin
            state <= IDLE;
            done  <= 1'b0;
          end
        START: begin
          start <= 1'b0;
          busy  <= 1'b1;
          state <= BUSY;
        end
        BUSY:
          if (Image_Done) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        default: state <= IDLE;
      endcase
  end
endmodule

// File: tb/tb_apb_image_bank.sv
// tb_apb_image_bank: scoreboard bench for apb_image_bank with directed APB/core vectors
module tb_apb_image_bank;
  logic clk = 0;
  logic rst, PSEL, PENABLE, PWRITE, Image_Done, start;
  logic [20:0] PADDR;
  logic [15:0] PWDATA, PRDATA;
  logic [7:0] Iwhite, M, Bthr, Amin, Amax, Bmin, Bmax, core_data;
  logic [8:0] Np, Nw;
  logic [9:0] core_addr;
  logic rd_fire = 0, cd_fire = 0, cd_req = 0;
  int npass = 0, ntot = 0, start_cnt = 0;
  typedef struct {string nm; logic [15:0] v;} exp_t;
  exp_t rq[$], cq[$];
  apb_image_bank dut (
    .clk(clk), .rst(rst), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .Iwhite(Iwhite), .M(M),
    .Bthr(Bthr), .Amin(Amin), .Amax(Amax), .Bmin(Bmin), .Bmax(Bmax), .Np(Np),
    .Nw(Nw), .start(start), .Image_Done(Image_Done), .core_addr(core_addr),
    .core_data(core_data)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  function automatic logic [7:0] pix(input int i);
    return 8'(i * 37 + 5);
  endfunction
  always @(posedge clk) begin
    rd_fire <= PSEL && PENABLE && !PWRITE;
    cd_fire <= cd_req;
  end
  always @(negedge clk) begin
    if (start) start_cnt++;
    if (rd_fire) begin
      if (rq.size() == 0) begin
        ntot++;
        $display("FAIL rd_unexpected: PRDATA=%0h with nothing expected", PRDATA);
      end else begin
        exp_t e;
        e = rq.pop_front();
        chk(e.nm, PRDATA, e.v);
      end
    end
    if (cd_fire) begin
      if (cq.size() == 0) begin
        ntot++;
        $display("FAIL cd_unexpected: core_data=%0h with nothing expected", core_data);
      end else begin
        exp_t e;
        e = cq.pop_front();
        chk(e.nm, core_data, e.v);
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input int a, input logic [15:0] d);
    PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = 21'(a); PWDATA = d;
    tick();
    PENABLE = 1;
    tick();
    PSEL = 0; PENABLE = 0;
  endtask
  task automatic rd(input string nm, input int a, input logic [15:0] exp);
    rq.push_back('{nm, exp});
    PSEL = 1; PENABLE = 0; PWRITE = 0; PADDR = 21'(a);
    tick();
    PENABLE = 1;
    tick();
    PSEL = 0; PENABLE = 0;
  endtask
  task automatic core_rd(input string nm, input int a, input logic [7:0] exp);
    cq.push_back('{nm, 16'(exp)});
    core_addr = 10'(a); cd_req = 1;
    tick();
    cd_req = 0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    rst = 1; PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = '0; PWDATA = '0;
    Image_Done = 0; core_addr = '0;
    repeat (3) tick();
    chk("rst_Iwhite", Iwhite, 0);
    chk("rst_Np", Np, 0);
    chk("rst_PRDATA", PRDATA, 0);
    chk("rst_start", start, 0);
    rst = 0;
    tick();
    rd("status_idle", 0, 0);
    wr(1, 16'h00FF);
    rd("rd_Iwhite", 1, 255);
    chk("Iwhite_out", Iwhite, 255);
    wr(2, 16'hFE04);
    wr(3, 16'h0004);
    wr(4, 16'h0002);
    wr(5, 16'hAB37);
    rd("rd_Np_upper_ignored", 2, 4);
    rd("rd_Bthr", 5, 16'h37);
    chk("Bthr_out", Bthr, 8'h37);
    PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = 21'd10; PWDATA = {8'hC0, pix(0)};
    tick();
    PENABLE = 1;
    for (int i = 0; i < 32; i++) begin
      PADDR = 21'(10 + i); PWDATA = {8'hC0, pix(i)};
      tick();
    end
    PSEL = 0; PENABLE = 0;
    rd("rd_pix0", 10, 16'(pix(0)));
    rd("rd_pix31", 41, 16'(pix(31)));
    wr(1034, 16'h005A);
    rd("rd_out_of_range", 1034, 0);
    rd("pix0_after_oor_write", 10, 16'(pix(0)));
    core_rd("core_pix16_idle", 16, pix(16));
    start_cnt = 0;
    wr(0, 1);
    rd("status_busy", 0, 1);
    chk("start_once", start_cnt, 1);
    wr(2, 7);
    wr(10, 99);
    wr(0, 1);
    rd("rd_Np_busy", 2, 4);
    chk("Np_busy_out", Np, 4);
    rd("rd_mem_busy", 10, 0);
    chk("no_restart_busy", start_cnt, 1);
    Image_Done = 1;
    tick();
    Image_Done = 0;
    rd("status_done", 0, 2);
    core_rd("core_wm0", 16, pix(16));
    rd("pix0_after_busy_write", 10, 16'(pix(0)));
    wr(0, 0);
    rd("status_back_idle", 0, 0);
    wr(2, 0);
    wr(0, 1);
    rd("status_err_np0", 0, 4);
    wr(2, 40); wr(3, 40);
    wr(0, 1);
    rd("status_err_40x40", 0, 4);
    wr(2, 256); wr(3, 1);
    wr(0, 1);
    rd("status_err_np256", 0, 4);
    wr(2, 31); wr(3, 8);
    wr(0, 1);
    rd("status_err_1025", 0, 4);
    chk("no_start_on_err", start_cnt, 1);
    wr(2, 30); wr(3, 11);
    wr(0, 1);
    rd("status_busy_1021", 0, 1);
    chk("start_1021", start_cnt, 2);
    rst = 1;
    tick();
    chk("rst_busy_PRDATA", PRDATA, 0);
    chk("rst_busy_core_data", core_data, 0);
    chk("rst_busy_M", M, 0);
    chk("rst_busy_Nw", Nw, 0);
    chk("rst_busy_start", start, 0);
    rst = 0;
    tick();
    rd("status_after_rst", 0, 0);
    rd("pix0_after_rst", 10, 16'(pix(0)));
    Image_Done = 1;
    tick();
    Image_Done = 0;
    rd("status_done_ignored", 0, 0);
    chk("start_after_rst", start_cnt, 2);
    repeat (3) tick();
    chk("rd_drain", rq.size(), 0);
    chk("cd_drain", cq.size(), 0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule

// File: doc/apb_image_bank.md
APB_IMAGE_BANK -- requirements
Module: apb_image_bank

Interface
REQ-001 SHALL have parameter Amba_Word, default 16, APB data width.
REQ-002 SHALL have parameter Amba_Addr_Depth, default 20; PADDR width is Amba_Addr_Depth+1.
REQ-003 SHALL have parameter Data_Depth, default 8, pixel and 8-bit parameter width.
REQ-004 SHALL have parameter Mem_Depth, default 1024, image words stored; core_addr width is clog2(Mem_Depth).
REQ-005 SHALL have one clock and a synchronous, active-high reset: clk input 1 (all logic on rising edge); rst input 1.
REQ-006 SHALL have these APB ports: PSEL input 1; PENABLE input 1; PWRITE input 1; PADDR input Amba_Addr_Depth+1; PWDATA input Amba_Word; PRDATA output Amba_Word.
REQ-007 SHALL have these register outputs: Iwhite, M, Bthr, Amin, Amax, Bmin, Bmax, each output Data_Depth; Np and Nw, each output 9.
REQ-008 SHALL have these core-side ports: start output 1, one-cycle run pulse; Image_Done input 1, core completion; core_addr input clog2(Mem_Depth), image word index; core_data output Data_Depth, registered read data.

Function
REQ-009 SHALL commit a write on each rising edge with PSEL&PENABLE&PWRITE; back-to-back access cycles with PENABLE held high SHALL each commit one write (no PREADY, zero wait states).
REQ-010 SHALL use this address map: 0 control/status; 1 Iwhite; 2 Np; 3 Nw; 4 M; 5 Bthr; 6 Amin; 7 Amax; 8 Bmin; 9 Bmax; 10..10+Mem_Depth-1 image memory, at word index PADDR-10.
REQ-011 SHALL store image memory as Mem_Depth x Data_Depth: primary image at index 0..Np*Np-1, then watermark image at Np*Np..Np*Np+Nw*Nw-1.
REQ-012 SHALL take Np and Nw from PWDATA[8:0] and all other registers and pixels from PWDATA[7:0]; upper bits are ignored.
REQ-013 SHALL ignore writes to addresses >= 10+Mem_Depth; reads of such addresses return 0.
REQ-014 SHALL update PRDATA on every edge with PSEL&!PWRITE, from PADDR, zero-extended; PRDATA holds its value otherwise.
REQ-015 SHALL return status on a read of address 0: bit0 busy, bit1 done, bit2 err, other bits 0.
REQ-016 SHALL use FSM states IDLE, START, BUSY, DONE.
REQ-017 IDLE or DONE, on a write of 1 to address 0: valid parameters -> START, clear done and err; invalid parameters -> stay, set err.
REQ-018 Parameters SHALL be valid only if Np!=0, Nw!=0, M!=0, Np*Np+Nw*Nw <= Mem_Depth, computed at full width with no truncation.
REQ-019 START SHALL drive start=1 for exactly one cycle, then go to BUSY.
REQ-020 BUSY SHALL assert busy=1, ignore all APB writes to every address, return 0 for APB reads of the memory region, and keep register reads functional.
REQ-021 BUSY, on Image_Done=1: -> DONE, with done=1 and busy=0; Image_Done in any other state SHALL be ignored.
REQ-022 SHALL accept register and memory writes in IDLE and DONE; a write of 0 to address 0 in DONE -> IDLE, clearing done.
REQ-023 SHALL present core_data one cycle after core_addr, from memory[core_addr], in every state.
REQ-024 A write of 1 to address 0 in START or BUSY SHALL have no effect.

Reset
REQ-025 On rst=1 at a rising edge, SHALL set all parameter registers, PRDATA, core_data, start, busy, done and err to 0, and the FSM to IDLE.
REQ-026 Image memory contents SHALL be unaffected by reset.
REQ-027 Reset asserted mid-BUSY SHALL abort to IDLE the next edge, with no start pulse and no done.

Verification
REQ-028 Write 255 at addr 1, then read addr 1 -> PRDATA=255 and Iwhite=255.
REQ-029 Write Np=4, Nw=4, M=2, 32 pixels back-to-back at addr 10..41, then write 1 at addr 0 -> start high exactly one cycle, status reads 1.
REQ-030 In BUSY, write 7 at addr 2 -> Np stays 4; read addr 10 returns 0.
REQ-031 Pulse Image_Done in BUSY -> status reads 2; core_addr=16 -> core_data equals the first watermark pixel next cycle.
REQ-032 Set Np=0, then write 1 at addr 0 -> no start pulse, status reads 4; write 40x40 config with Mem_Depth=1024 -> err also.
REQ-033 Assert rst during BUSY -> status 0 and all outputs 0; memory word at addr 10 is unchanged on read-back.
